// File: rtl/mult_ctrl_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mult_ctrl_pkg : shared types for the multiply sequencing controller
// Rev 1.0
// ------------------------------------------------------------------
package mult_ctrl_pkg;

  localparam int REG_W = 32;
  localparam int CNT_W = 7;

  typedef logic [REG_W-1:0]   reg_bus_t;
  typedef logic [2*REG_W-1:0] double_reg_bus_t;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_RUN  = 2'd1,
    MC_FIX  = 2'd2,
    MC_WB   = 2'd3
  } mc_state_t;

  // Unsigned high word = signed high word + (a<0 ? b : 0) + (b<0 ? a : 0), mod 2^32
  function automatic reg_bus_t unsigned_hi_corr(input reg_bus_t a, input reg_bus_t b);
    reg_bus_t ca;
    reg_bus_t cb;
    ca = a[REG_W-1] ? b : '0;
    cb = b[REG_W-1] ? a : '0;
    return ca + cb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/umul_fix.sv
`default_nettype none
// ------------------------------------------------------------------
// umul_fix : converts the signed product high word to the MULTU high word
// Rev 1.0
// ------------------------------------------------------------------
module umul_fix
  import mult_ctrl_pkg::*;
(
  input  logic     sgn,
  input  reg_bus_t prod_hi,
  input  reg_bus_t op1,
  input  reg_bus_t op2,
  output reg_bus_t hi_fix
);

  reg_bus_t corr;

  always_comb begin
    corr   = sgn ? '0 : unsigned_hi_corr(op1, op2);
    hi_fix = prod_hi + corr;
  end

endmodule
`default_nettype wire

// File: rtl/mult_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// mult_ctrl : MULT/MULTU sequencer around the iterative Booth multiplier
// Rev 1.0
// ------------------------------------------------------------------
module mult_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 40
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_signed,
  input  reg_bus_t        req_op1,
  input  reg_bus_t        req_op2,
  input  logic            annul_i,
  output logic            stall_req,
  output logic            hilo_we,
  output reg_bus_t        hi_o,
  output reg_bus_t        lo_o,
  output logic            err_o,
  output reg_bus_t        m_op1,
  output reg_bus_t        m_op2,
  output logic            m_start,
  input  logic            m_done,
  input  double_reg_bus_t m_result
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  mc_state_t        state;
  mc_state_t        state_nxt;
  logic             sgn_q;
  double_reg_bus_t  prod_q;
  logic [CNT_W-1:0] cnt;
  reg_bus_t         hi_fix;

  logic launch;
  logic run_annul;
  logic run_done;
  logic run_timeout;
  logic fix_commit;

  umul_fix u_umul_fix (
    .sgn     (sgn_q),
    .prod_hi (prod_q[2*REG_W-1:REG_W]),
    .op1     (m_op1),
    .op2     (m_op2),
    .hi_fix  (hi_fix)
  );

  always_comb begin
    launch      = (state == MC_IDLE) & req_valid & ~annul_i & ~m_done;
    run_annul   = (state == MC_RUN) & annul_i;
    run_done    = (state == MC_RUN) & ~annul_i & m_done;
    run_timeout = (state == MC_RUN) & ~annul_i & ~m_done & (cnt == CNT_LAST);
    fix_commit  = (state == MC_FIX) & ~annul_i;
  end

  always_comb begin
    state_nxt = state;
    stall_req = 1'b0;
    hilo_we   = 1'b0;
    case (state)
      MC_IDLE: begin
        stall_req = req_valid & ~annul_i;
        if (launch) state_nxt = MC_RUN;
      end
      MC_RUN: begin
        stall_req = 1'b1;
        if (run_annul || run_timeout) state_nxt = MC_IDLE;
        else if (run_done)            state_nxt = MC_FIX;
      end
      MC_FIX: begin
        stall_req = 1'b1;
        state_nxt = fix_commit ? MC_WB : MC_IDLE;
      end
      MC_WB: begin
        hilo_we   = ~annul_i;
        state_nxt = MC_IDLE;
      end
      default: state_nxt = MC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= MC_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_start <= 1'b0;
      err_o   <= 1'b0;
      m_op1   <= '0;
      m_op2   <= '0;
      hi_o    <= '0;
      lo_o    <= '0;
      prod_q  <= '0;
      cnt     <= '0;
      sgn_q   <= 1'b0;
    end else begin
      err_o <= 1'b0;
      if (launch) begin
        m_op1   <= req_op1;
        m_op2   <= req_op2;
        sgn_q   <= req_signed;
        m_start <= 1'b1;
        cnt     <= '0;
      end
      if (run_annul) begin
        m_start <= 1'b0;
      end else if (run_done) begin
        prod_q  <= m_result;
        m_start <= 1'b0;
      end else if (run_timeout) begin
        err_o   <= 1'b1;
        m_start <= 1'b0;
      end else if (state == MC_RUN) begin
        cnt <= cnt + CNT_W'(1);
      end
      // HI/LO only ever change on an un-annulled FIX cycle
      if (fix_commit) begin
        lo_o <= prod_q[REG_W-1:0];
        hi_o <= hi_fix;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_mult_ctrl : directed self-checking bench for mult_ctrl
// Rev 1.0
// ------------------------------------------------------------------
module tb_mult_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_signed;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic        annul_i;
  logic        stall_req;
  logic        hilo_we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        err_o;
  logic [31:0] m_op1;
  logic [31:0] m_op2;
  logic        m_start;
  logic        m_done;
  logic [63:0] m_result;

  int checks = 0;
  int errors = 0;

  // multiplier model knobs
  int lat        = 3;
  bit never_done = 0;
  int hold_extra = 0;
  int mcnt;
  int hold_cnt;

  mult_ctrl #(.MAX_WAIT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_signed (req_signed),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .annul_i    (annul_i),
    .stall_req  (stall_req),
    .hilo_we    (hilo_we),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .err_o      (err_o),
    .m_op1      (m_op1),
    .m_op2      (m_op2),
    .m_start    (m_start),
    .m_done     (m_done),
    .m_result   (m_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Done rises lat edges after m_start is seen, then drops hold_extra edges after m_start falls
  always @(posedge clk) begin
    if (!rst) begin
      m_done   <= 1'b0;
      m_result <= '0;
      mcnt     <= 0;
      hold_cnt <= 0;
    end else if (m_start && !m_done) begin
      if (!never_done && (mcnt + 1 == lat)) begin
        m_done   <= 1'b1;
        m_result <= $signed({{32{m_op1[31]}}, m_op1}) * $signed({{32{m_op2[31]}}, m_op2});
        hold_cnt <= hold_extra;
      end
      mcnt <= mcnt + 1;
    end else if (m_done) begin
      if (!m_start) begin
        if (hold_cnt == 0) m_done <= 1'b0;
        else               hold_cnt <= hold_cnt - 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; holds the request until the write strobe is seen
  task automatic run_req(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output int stall_n, output int we_n, output bit we_at_fall);
    bit prev_stall;
    bit got;
    stall_n = 0; we_n = 0; we_at_fall = 0; prev_stall = 0; got = 0;
    req_valid = 1'b1; req_signed = s; req_op1 = a; req_op2 = b;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (stall_req) stall_n++;
      if (hilo_we) begin
        we_n++;
        got = 1;
        if (prev_stall && !stall_req) we_at_fall = 1;
      end
      prev_stall = stall_req;
      @(negedge clk);
    end
    req_valid = 1'b0;
    #1;
    if (hilo_we) we_n++;
    @(negedge clk);
  endtask

  initial begin
    int  sn;
    int  wn;
    bit  wf;
    int  en;
    bit  ef;
    bit  prev;
    int  blocked;
    bit  got;

    rst = 1'b0; req_valid = 1'b0; req_signed = 1'b0;
    req_op1 = '0; req_op2 = '0; annul_i = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", 64'(stall_req), 64'd0);
    check("rst_we",    64'(hilo_we),   64'd0);
    check("rst_start", 64'(m_start),   64'd0);
    check("rst_err",   64'(err_o),     64'd0);
    check("rst_hilo",  {hi_o, lo_o},   64'd0);
    check("rst_ops",   {m_op1, m_op2}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // MULT -3 * 7
    run_req(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, sn, wn, wf);
    check("mult_neg_hilo",  {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFEB);
    check("mult_neg_stall", 64'(sn), 64'd6);
    check("mult_neg_we",    64'(wn), 64'd1);
    check("mult_neg_we_at_fall", 64'(wf), 64'd1);
    check("mult_neg_start_low",  64'(m_start), 64'd0);

    // MULTU / MULT with all-ones operands
    run_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, sn, wn, wf);
    check("multu_ff_hilo", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);
    check("multu_ff_we",   64'(wn), 64'd1);
    run_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, sn, wn, wf);
    check("mult_ff_hilo",  {hi_o, lo_o}, 64'h0000_0000_0000_0001);

    // MULTU 0x80000000 * 2 = 2^32
    run_req(32'h8000_0000, 32'h0000_0002, 1'b0, sn, wn, wf);
    check("multu_msb_hilo", {hi_o, lo_o}, 64'h0000_0001_0000_0000);
    check("multu_msb_stall", 64'(sn), 64'd6);

    // annul on the 3rd RUN cycle
    lat = 10;
    req_valid = 1'b1; req_signed = 1'b1; req_op1 = 32'd9; req_op2 = 32'd9;
    repeat (3) @(negedge clk);
    annul_i = 1'b1;
    #1;
    check("annul_run_stall", 64'(stall_req), 64'd1);
    check("annul_run_we",    64'(hilo_we),   64'd0);
    @(negedge clk);
    annul_i = 1'b0; req_valid = 1'b0;
    #1;
    check("annul_start_low", 64'(m_start),   64'd0);
    check("annul_stall_low", 64'(stall_req), 64'd0);
    wn = 0;
    for (int i = 0; i < 12; i++) begin
      if (hilo_we || m_start) wn++;
      @(negedge clk);
      #1;
    end
    check("annul_no_activity", 64'(wn), 64'd0);
    check("annul_hilo_kept", {hi_o, lo_o}, 64'h0000_0001_0000_0000);
    @(negedge clk);

    // watchdog with a multiplier that never finishes (MAX_WAIT = 8)
    never_done = 1; lat = 3;
    req_valid = 1'b1; req_signed = 1'b1; req_op1 = 32'd7; req_op2 = 32'd9;
    sn = 0; en = 0; ef = 0; wn = 0; prev = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 1) req_valid = 1'b0;
      #1;
      if (stall_req) sn++;
      if (hilo_we) wn++;
      if (err_o) begin
        en++;
        if (prev && !stall_req) ef = 1;
      end
      prev = stall_req;
      @(negedge clk);
    end
    check("wd_stall_cycles", 64'(sn), 64'd9);
    check("wd_err_pulses",   64'(en), 64'd1);
    check("wd_err_at_fall",  64'(ef), 64'd1);
    check("wd_no_write",     64'(wn), 64'd0);
    check("wd_start_low",    64'(m_start), 64'd0);
    never_done = 0;

    // back-to-back with done held high after the first run
    hold_extra = 3;
    req_valid = 1'b1; req_signed = 1'b1; req_op1 = 32'd3; req_op2 = 32'd4;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (hilo_we) got = 1;
      else @(negedge clk);
    end
    check("b2b_first_we", 64'(got), 64'd1);
    check("b2b_first_lo", 64'(lo_o), 64'd12);
    req_op1 = 32'h10; req_op2 = 32'h20;
    blocked = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      #1;
      if (m_start) got = 1;
      else if (stall_req && m_done) blocked++;
    end
    hold_extra = 0;
    check("b2b_launched", 64'(got), 64'd1);
    check("b2b_blocked_cycles", 64'(blocked), 64'd2);
    check("b2b_new_ops", {m_op1, m_op2}, 64'h0000_0010_0000_0020);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (hilo_we) got = 1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    check("b2b_second_hilo", {hi_o, lo_o}, 64'h0000_0000_0000_0200);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);

    // reset mid-RUN
    lat = 10;
    req_valid = 1'b1; req_signed = 1'b1; req_op1 = 32'h11; req_op2 = 32'h22;
    repeat (3) @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    #1;
    check("mrst_start", 64'(m_start),   64'd0);
    check("mrst_hilo",  {hi_o, lo_o},   64'd0);
    check("mrst_err",   64'(err_o),     64'd0);
    check("mrst_we",    64'(hilo_we),   64'd0);
    check("mrst_stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    rst = 1'b1; lat = 3;
    @(negedge clk);
    run_req(32'd5, 32'd6, 1'b1, sn, wn, wf);
    check("post_rst_hilo",  {hi_o, lo_o}, 64'd30);
    check("post_rst_stall", 64'(sn), 64'd6);
    check("post_rst_we",    64'(wn), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_ctrl.md
# mult_ctrl

Sequencing controller for the iterative signed Booth multiplier in the EX stage. It accepts MULT/MULTU requests from EX and holds the pipeline through `stall_req` while the multiplier runs. It drives the multiplier's start/done handshake and converts the signed 64-bit product to an unsigned product for MULTU. It then issues a single HI/LO write, and also handles flush (annul) and a done-timeout watchdog.

## Interface
- `MAX_WAIT`, default 40: RUN-state cycle limit before the watchdog aborts; range 2..127.
- `clk` in 1: clock. All logic updates on the rising edge.
- `rst` in 1: reset, synchronous, active-low (`rst==0` resets on the clock edge). The multiplier is reset by the same signal.
- `req_valid` in 1: EX holds a MULT/MULTU and keeps it asserted until it is consumed.
- `req_signed` in 1: 1 = MULT, 0 = MULTU.
- `req_op1`, `req_op2` in 32 each (`RegBus`): operands.
- `annul_i` in 1: flush of the instruction in EX.
- `stall_req` out 1: combinational stall request to the pipeline controller.
- `hilo_we` out 1: combinational one-cycle HI/LO write strobe.
- `hi_o`, `lo_o` out 32 each: registered product halves.
- `err_o` out 1: registered one-cycle watchdog-abort pulse.
- `m_op1`, `m_op2` out 32 each: registered operands to the multiplier.
- `m_start` out 1: registered; held high for the whole run.
- `m_done` in 1: multiplier finished. `m_result` is valid whenever `m_done` is sampled high.
- `m_result` in 64: signed product.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: multiplier active.
  - FIX: unsigned correction, result registered.
  - WB: write-back.
- Registers: `sgn_q`, `prod_q[63:0]` and a 7-bit `cnt`.
- IDLE:
  - Launch condition is `req_valid & ~annul_i & ~m_done`. On launch: `m_op1/m_op2 <= req_op*`, `sgn_q <= req_signed`, `m_start <= 1`, `cnt <= 0`, go to RUN.
  - If `req_valid` is high but `m_done` is still high from the previous run, stay in IDLE (stall stays asserted).
- RUN, priority is annul > done > watchdog:
  - `annul_i`: `m_start <= 0`, go to IDLE, no write.
  - `m_done`: `prod_q <= m_result`, `m_start <= 0`, go to FIX.
  - `cnt == MAX_WAIT-1`: `err_o <= 1` for one cycle, `m_start <= 0`, go to IDLE, no write.
  - Otherwise `cnt <= cnt+1`.
- FIX:
  - `lo_o <= prod_q[31:0]`.
  - `hi_o <= prod_q[63:32] + (sgn_q ? 0 : ((m_op1[31] ? m_op2 : 0) + (m_op2[31] ? m_op1 : 0)))`, computed modulo 2^32 with carries discarded.
  - Go to WB, or to IDLE without updating `hi_o/lo_o` if `annul_i` is high.
- WB:
  - `hilo_we = ~annul_i`.
  - The request is consumed in this cycle; go to IDLE unconditionally.
- `stall_req = (IDLE & req_valid & ~annul_i) | RUN | FIX`. It is 0 in WB.
- `m_op1/m_op2` stay stable from launch until the next launch.

## Timing
- Reset values: state IDLE; `m_start`, `err_o`, `m_op1`, `m_op2`, `hi_o`, `lo_o`, `prod_q`, `cnt` all 0. Combinational outputs therefore read 0 with no request pending.
- Reset mid-run: the next edge forces IDLE and `m_start=0` with no write. The multiplier is reset by the same edge.
- Latency: if `m_done` is first sampled high N cycles after `m_start` rises, then `stall_req` is high for N+2 cycles (launch cycle, N RUN cycles, FIX). `hilo_we` rises in the following cycle, the same cycle `stall_req` falls.
- Back-to-back: a new request is held in IDLE with `stall_req=1` until `m_done` is sampled low. There is no overlap of runs.
- Annul in IDLE: no launch, no stall.
- Annul in WB: strobe suppressed, but `hi_o/lo_o` keep the new value (harmless because `hilo_we=0`).
- Watchdog abort: `err_o` and the `stall_req` fall are visible in the cycle after the MAX_WAIT-th RUN cycle.

## Structure
- Shared defines file (existing one):
  - State encodings `MC_IDLE`, `MC_RUN`, `MC_FIX`, `MC_WB`, 2 bits.
  - Reuse `RegBus`.
  - Add `DoubleRegBus` 63:0.
- Sub-module `umul_fix`: purely combinational. Takes the signed product high half, the operands and `sgn`, and returns the corrected HI word. It is kept separate for unit testing.
- The EX top level instantiates `mult_ctrl` beside the Booth multiplier and wires the `m_*` ports directly.

## Test plan
- MULT `0xFFFFFFFD` × `0x00000007` → `hi_o=0xFFFFFFFF`, `lo_o=0xFFFFFFEB`. `hilo_we` high exactly one cycle, coinciding with the `stall_req` fall. Stall length equals N+2.
- MULTU `0xFFFFFFFF` × `0xFFFFFFFF` → `hi_o=0xFFFFFFFE`, `lo_o=0x00000001`. MULT with the same operands → hi 0, lo 1.
- `annul_i` pulsed on the 3rd RUN cycle → `m_start` low next edge, state IDLE, no `hilo_we`, `stall_req` low, `hi_o/lo_o` unchanged.
- Multiplier model never raises done, `MAX_WAIT=8` → `err_o` one-cycle pulse after 8 RUN cycles, `stall_req` drops, no write.
- Second request while model holds `m_done` high for 2 extra cycles → stays IDLE with stall for 2 cycles, then launches with the new operands.
- `rst=0` mid-RUN → next edge: `m_start=0`, `hi_o/lo_o/err_o=0`, no `hilo_we`. After release, a fresh MULT 5×6 gives lo 30.
